// File: rtl/rv_decode_pkg.sv
// ============================================================================
// Module  : rv_decode_pkg
// Brief   : Shared types and constants for the rv_decode_issue front end:
//           op_e codes, opcode/funct constants, the decoded_t FIFO payload and
//           immediate-extraction helpers.
//           The M-extension funct3 constants only exist when RV_MEXT_EN is
//           defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_decode_pkg;

  // Internal width of the pc/imm payload; the top slices this to XLEN.
  localparam int DATA_XLEN = 64;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND,
    OP_ADDW, OP_SUBW,
    OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_e;

  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_JALR      = 7'h67;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;

`ifdef RV_MEXT_EN
  localparam logic [2:0] F3_MUL  = 3'd0;
  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;
`endif

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [5:0] F6_LOGIC  = 6'h00;
  localparam logic [5:0] F6_ARITH  = 6'h10;

  typedef struct packed {
    op_e                  op;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [DATA_XLEN-1:0] imm;
    logic [DATA_XLEN-1:0] pc;
    logic                 wr_en;
    logic                 illegal;
  } decoded_t;

  function automatic logic [DATA_XLEN-1:0] imm_i(input logic [31:0] insn);
    return {{(DATA_XLEN-12){insn[31]}}, insn[31:20]};
  endfunction

  function automatic logic [DATA_XLEN-1:0] imm_u(input logic [31:0] insn);
    return {{(DATA_XLEN-32){insn[31]}}, insn[31:12], 12'h000};
  endfunction

  function automatic logic [DATA_XLEN-1:0] imm_j(input logic [31:0] insn);
    return {{(DATA_XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20],
            insn[30:21], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_issue_fifo.sv
// ============================================================================
// Module  : rv_issue_fifo
// Brief   : DEPTH-entry FIFO of decoded_t with synchronous flush. The head is
//           presented combinationally from storage (zero when empty); a full
//           FIFO never accepts a push, even alongside a pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_issue_fifo
  import rv_decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     i_push,
  input  decoded_t i_wdata,
  input  logic     i_pop,
  output decoded_t o_head,
  output logic     o_valid,
  output logic     o_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rv_issue_fifo: DEPTH must be a power of 2 and at least 2");
  end

  decoded_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_valid = (r_count != '0);
  assign o_ready = (r_count < C_DEPTH);
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && o_valid;
  assign o_head  = o_valid ? r_mem[r_rptr] : '0;

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/rv_decode_issue.sv
// ============================================================================
// Module  : rv_decode_issue
// Brief   : RV64IM decode/issue stage. Decodes raw instruction words into
//           op/rd/rs1/rs2/imm, buffers them in rv_issue_fifo and issues them
//           over a valid/ready handshake, counting issued and illegal entries.
//           Optional macro RV_MEXT_EN enables mul/div/rem (and W forms);
//           without it those encodings decode as OP_ILLEGAL.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decode_issue
  import rv_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_wr_en,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  decoded_t         w_dec;
  decoded_t         w_head;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [5:0]       w_f6;
  logic             w_pop;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_illegal;

  assign w_f3 = in_insn[14:12];
  assign w_f7 = in_insn[31:25];
  assign w_f6 = in_insn[31:26];

  // Combinational decode of the incoming word; register fields are always
  // extracted raw so illegal entries still carry them downstream.
  always_comb begin
    w_dec     = '0;
    w_dec.op  = OP_ILLEGAL;
    w_dec.rd  = in_insn[11:7];
    w_dec.rs1 = in_insn[19:15];
    w_dec.rs2 = in_insn[24:20];
    w_dec.pc  = DATA_XLEN'(in_pc);
    case (in_insn[6:0])
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_ADD:  w_dec.op = OP_ADD;
            F3_XOR:  w_dec.op = OP_XOR;
            F3_OR:   w_dec.op = OP_OR;
            F3_AND:  w_dec.op = OP_AND;
            default: w_dec.op = OP_ILLEGAL;
          endcase
        end else if ((w_f7 == F7_ALT) && (w_f3 == F3_ADD)) begin
          w_dec.op = OP_SUB;
        end
`ifdef RV_MEXT_EN
        else if (w_f7 == F7_MULDIV) begin
          case (w_f3)
            F3_MUL:  w_dec.op = OP_MUL;
            F3_DIV:  w_dec.op = OP_DIV;
            F3_DIVU: w_dec.op = OP_DIVU;
            F3_REM:  w_dec.op = OP_REM;
            F3_REMU: w_dec.op = OP_REMU;
            default: w_dec.op = OP_ILLEGAL;
          endcase
        end
`endif
      end
      OPC_OP_32: begin
        if ((w_f7 == F7_BASE) && (w_f3 == F3_ADD)) begin
          w_dec.op = OP_ADDW;
        end else if ((w_f7 == F7_ALT) && (w_f3 == F3_ADD)) begin
          w_dec.op = OP_SUBW;
        end
`ifdef RV_MEXT_EN
        else if (w_f7 == F7_MULDIV) begin
          case (w_f3)
            F3_MUL:  w_dec.op = OP_MULW;
            F3_DIV:  w_dec.op = OP_DIVW;
            F3_DIVU: w_dec.op = OP_DIVUW;
            F3_REM:  w_dec.op = OP_REMW;
            F3_REMU: w_dec.op = OP_REMUW;
            default: w_dec.op = OP_ILLEGAL;
          endcase
        end
`endif
      end
      OPC_OP_IMM: begin
        w_dec.imm = imm_i(in_insn);
        case (w_f3)
          F3_ADD: w_dec.op = OP_ADDI;
          F3_SLT: w_dec.op = OP_SLTI;
          F3_XOR: w_dec.op = OP_XORI;
          F3_OR:  w_dec.op = OP_ORI;
          F3_AND: w_dec.op = OP_ANDI;
          F3_SLL: begin
            w_dec.imm = DATA_XLEN'(in_insn[25:20]);
            if (w_f6 == F6_LOGIC) w_dec.op = OP_SLLI;
          end
          F3_SR: begin
            w_dec.imm = DATA_XLEN'(in_insn[25:20]);
            if (w_f6 == F6_LOGIC)      w_dec.op = OP_SRLI;
            else if (w_f6 == F6_ARITH) w_dec.op = OP_SRAI;
          end
          default: w_dec.op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM_32: begin
        // W shifts take a 5-bit shamt; insn[25] set is therefore illegal.
        case (w_f3)
          F3_ADD: begin
            w_dec.imm = imm_i(in_insn);
            w_dec.op  = OP_ADDIW;
          end
          F3_SLL: begin
            w_dec.imm = DATA_XLEN'(in_insn[24:20]);
            if (w_f7 == F7_BASE) w_dec.op = OP_SLLIW;
          end
          F3_SR: begin
            w_dec.imm = DATA_XLEN'(in_insn[24:20]);
            if (w_f7 == F7_BASE)     w_dec.op = OP_SRLIW;
            else if (w_f7 == F7_ALT) w_dec.op = OP_SRAIW;
          end
          default: w_dec.op = OP_ILLEGAL;
        endcase
      end
      OPC_LUI: begin
        w_dec.imm = imm_u(in_insn);
        w_dec.op  = OP_LUI;
      end
      OPC_AUIPC: begin
        w_dec.imm = imm_u(in_insn);
        w_dec.op  = OP_AUIPC;
      end
      OPC_JAL: begin
        w_dec.imm = imm_j(in_insn);
        w_dec.op  = OP_JAL;
      end
      OPC_JALR: begin
        w_dec.imm = imm_i(in_insn);
        if (w_f3 == F3_ADD) w_dec.op = OP_JALR;
      end
      default: w_dec.op = OP_ILLEGAL;
    endcase
    w_dec.illegal = (w_dec.op == OP_ILLEGAL);
    w_dec.wr_en   = !w_dec.illegal && (w_dec.rd != 5'd0);
    if (w_dec.illegal) w_dec.imm = '0;
  end

  rv_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .i_push  (in_valid),
    .i_wdata (w_dec),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_valid (out_valid),
    .o_ready (in_ready)
  );

  assign out_op      = w_head.op;
  assign out_rd      = w_head.rd;
  assign out_rs1     = w_head.rs1;
  assign out_rs2     = w_head.rs2;
  assign out_imm     = w_head.imm[XLEN-1:0];
  assign out_pc      = w_head.pc[XLEN-1:0];
  assign out_wr_en   = w_head.wr_en;
  assign out_illegal = w_head.illegal;

  // A flushed pop never reaches the executer, so it is not counted.
  assign w_pop = out_valid && out_ready && !flush;

  // Free-running statistics; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued  <= '0;
      r_illegal <= '0;
    end else if (w_pop) begin
      r_issued <= r_issued + CNT_W'(1);
      if (w_head.illegal) r_illegal <= r_illegal + CNT_W'(1);
    end
  end

  assign issued_cnt  = r_issued;
  assign illegal_cnt = r_illegal;

endmodule

`default_nettype wire
